// File: rtl/sram_bank_pkg.sv
// Shared types and macro constants for the banked SRAM array.
package sram_bank_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int MACRO_WORDS = 512;
  localparam int MACRO_DW    = 32;
  localparam int MACRO_AW    = 9;

  // A single bank still needs a 1-bit index so the mux select is never zero width.
  function automatic int bank_sel_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One 1RW SRAM bank with active-high enables: the sky130 macro under ASIC,
// otherwise a behavioural model with one cycle read latency.
module sram_bank
  import sram_bank_pkg::*;
#(
  parameter int WORDS = MACRO_WORDS,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

`ifdef ASIC
  sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
    .clk0   (clk),
    .csb0   (~en),
    .web0   (~we),
    .wmask0 (be),
    .addr0  (addr),
    .din0   (wdata),
    .dout0  (rdata),
    .clk1   (clk),
    .csb1   (1'b1),
    .addr1  ({MACRO_AW{1'b0}}),
    .dout1  ()
  );
`else
  logic [31:0] mem [WORDS];

  // Output holds its last read value during writes and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end
`endif

endmodule

// File: rtl/sram_bank_array.sv
// Multi-bank single-port RAM with req/gnt/rvalid handshake, range error,
// write bypass loopback and optional post-reset zero fill.
//
//   state | meaning
//   INIT  | zero-filling word init_cnt_q in every bank, no grants
//   READY | accepting one access per cycle
module sram_bank_array
  import sram_bank_pkg::*;
#(
  parameter int RAM_SIZE       = 8192,
  parameter int BANK_WORDS     = 512,
  parameter int NUM_BANKS      = RAM_SIZE / (BANK_WORDS * 4),
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  input  logic                  bypass_en_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  init_busy_o
);

  localparam int WORD_AW = $clog2(BANK_WORDS);
  localparam int BANK_AW = bank_sel_w(NUM_BANKS);

  state_e state_q, state_d;
  logic [WORD_AW-1:0] init_cnt_q, init_cnt_d;

  logic [WORD_AW-1:0] word_idx;
  logic [BANK_AW-1:0] bank_idx;
  logic               in_range;
  logic               acc_go;

  logic               macro_we;
  logic [3:0]         macro_be;
  logic [WORD_AW-1:0] macro_addr;
  logic [31:0]        macro_wdata;
  logic               bank_en    [NUM_BANKS];
  logic [31:0]        bank_rdata [NUM_BANKS];

  logic               rvalid_q, err_q, rd_q, byp_q;
  logic [BANK_AW-1:0] bank_q;
  logic [31:0]        byp_data_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= CLEAR_ON_RESET ? INIT : READY;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == WORD_AW'(BANK_WORDS - 1)) state_d = READY;
      end
      READY: ;
      default: state_d = READY;
    endcase
  end

  assign init_busy_o = (state_q == INIT);
  assign gnt_o       = req_i & (state_q == READY);

  // ------------------------------------------------------- address decode
  assign word_idx = addr_i[WORD_AW+1:2];
  assign in_range = ({1'b0, addr_i} < (ADDR_WIDTH+1)'(RAM_SIZE));

  if (NUM_BANKS > 1) begin : g_bank_idx
    assign bank_idx = addr_i[WORD_AW+2 +: BANK_AW];
  end else begin : g_bank_idx_single
    assign bank_idx = '0;
  end

  // Bypass writes and out-of-range accesses never touch a macro.
  assign acc_go = gnt_o & in_range & ~(we_i & bypass_en_i);

  // ------------------------------------------------------------ macros
  assign macro_we    = init_busy_o | we_i;
  assign macro_be    = init_busy_o ? 4'hF : be_i;
  assign macro_addr  = init_busy_o ? init_cnt_q : word_idx;
  assign macro_wdata = init_busy_o ? 32'h0 : wdata_i;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_en[b] = init_busy_o | (acc_go & (bank_idx == BANK_AW'(b)));

    sram_bank #(
      .WORDS (BANK_WORDS),
      .AW    (WORD_AW)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en[b]),
      .we    (macro_we),
      .be    (macro_be),
      .addr  (macro_addr),
      .wdata (macro_wdata),
      .rdata (bank_rdata[b])
    );
  end

  // ---------------------------------------------------------- response
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      byp_q      <= 1'b0;
      bank_q     <= '0;
      byp_data_q <= '0;
    end else begin
      rvalid_q <= gnt_o;
      err_q    <= gnt_o & ~in_range;
      rd_q     <= gnt_o & in_range & ~we_i;
      byp_q    <= gnt_o & in_range & we_i & bypass_en_i;
      if (gnt_o) begin
        bank_q     <= bank_idx;
        byp_data_q <= wdata_i;
      end
    end
  end

  // Read data is taken directly from the macro outputs, no output register.
  always_comb begin
    rdata_o = '0;
    if (rd_q)       rdata_o = bank_rdata[bank_q];
    else if (byp_q) rdata_o = byp_data_q;
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_sram_bank_array.sv
// Directed self-checking bench for sram_bank_array (4 banks x 512 words).
module tb_sram_bank_array;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        bypass_en_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        init_busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_bank_array #(
    .RAM_SIZE       (8192),
    .BANK_WORDS     (512),
    .ADDR_WIDTH     (32),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .bypass_en_i (bypass_en_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .init_busy_o (init_busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a clock edge; counts busy cycles until fill ends.
  task automatic count_busy(output int n, output bit gnt_seen, output bit rv_seen);
    n = 0;
    gnt_seen = 1'b0;
    rv_seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!init_busy_o) break;
      n++;
      if (gnt_o) gnt_seen = 1'b1;
      if (rvalid_o) rv_seen = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // Single access: called just after an edge, returns just after the response edge.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input logic byp,
                        input logic [31:0] exp_rd, input logic exp_err);
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd; bypass_en_i = byp;
    #1 check({tag, ".gnt"}, 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0; bypass_en_i = 1'b0;
    check({tag, ".rvalid"}, 32'(rvalid_o), 32'd1);
    check({tag, ".rdata"}, rdata_o, exp_rd);
    check({tag, ".err"}, 32'(err_o), 32'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    bit          gs, rs;
    logic [31:0] baddr [4];
    logic [31:0] bdata [4];
    int          order [4];

    rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = 4'h0;
    wdata_i = '0; bypass_en_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rvalid", 32'(rvalid_o), 32'd0);
    check("rst.rdata", rdata_o, 32'h0);
    check("rst.err", 32'(err_o), 32'd0);
    check("rst.gnt", 32'(gnt_o), 32'd0);
    check("rst.busy", 32'(init_busy_o), 32'd1);

    // Release reset with a read of the last word already requested.
    rst_i = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1FFC;
    count_busy(n, gs, rs);
    check("fill.busy_cycles", 32'(n), 32'd512);
    check("fill.no_gnt", 32'(gs), 32'd0);
    check("fill.no_rvalid", 32'(rs), 32'd0);
    check("first.gnt", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0;
    check("first.rvalid", 32'(rvalid_o), 32'd1);
    check("first.rdata", rdata_o, 32'h0);
    check("first.err", 32'(err_o), 32'd0);
    @(posedge clk); #1;
    check("idle.rvalid", 32'(rvalid_o), 32'd0);
    check("idle.rdata", rdata_o, 32'h0);

    // Masked write then back-to-back read of the same word.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0804; be_i = 4'b0101; wdata_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("raw.wr_rvalid", 32'(rvalid_o), 32'd1);
    check("raw.wr_rdata", rdata_o, 32'h0);
    we_i = 1'b0;
    #1 check("raw.rd_gnt", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0;
    check("raw.rd_rvalid", 32'(rvalid_o), 32'd1);
    check("raw.rd_rdata", rdata_o, 32'h00AD00EF);
    @(posedge clk); #1;

    // Same word offset in every bank, distinct data, pipelined reads in mixed order.
    for (int b = 0; b < 4; b++) begin
      baddr[b] = 32'h0000_0014 + 32'(b) * 32'h800;
      bdata[b] = 32'hB0B0_0000 + 32'(b) * 32'h1111;
      access("bank.wr", 1'b1, baddr[b], 4'hF, bdata[b], 1'b0, 32'h0, 1'b0);
    end
    order[0] = 0; order[1] = 2; order[2] = 1; order[3] = 3;
    req_i = 1'b1; we_i = 1'b0; addr_i = baddr[order[0]];
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("bank.rd_rvalid", 32'(rvalid_o), 32'd1);
      check("bank.rd_rdata", rdata_o, bdata[order[k-1]]);
      if (k < 4) addr_i = baddr[order[k]];
      else       req_i = 1'b0;
    end
    access("bank.keep0804", 1'b0, 32'h0804, 4'h0, 32'h0, 1'b0, 32'h00AD00EF, 1'b0);

    // Out of range: read at RAM_SIZE, write that would alias bank 0 word 1.
    access("oor.rd", 1'b0, 32'h2000, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    access("oor.wr", 1'b1, 32'h2004, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1);
    access("oor.byp", 1'b1, 32'h2008, 4'hF, 32'h55AA55AA, 1'b1, 32'h0, 1'b1);
    access("oor.unchanged", 1'b0, 32'h0004, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    access("edge.last", 1'b0, 32'h1FFC, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Bypass loopback leaves memory untouched; bypass on reads is ignored.
    access("byp.pre", 1'b1, 32'h0010, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    access("byp.wr", 1'b1, 32'h0010, 4'hF, 32'h12345678, 1'b1, 32'h12345678, 1'b0);
    access("byp.rd", 1'b0, 32'h0010, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);
    access("byp.rd_en", 1'b0, 32'h0010, 4'h0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);

    // Reset in the same cycle as a grant kills the response.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0010; rst_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0; rst_i = 1'b0;
    check("kill.rvalid", 32'(rvalid_o), 32'd0);
    check("kill.rdata", rdata_o, 32'h0);
    check("kill.busy", 32'(init_busy_o), 32'd1);

    // Reset at fill cycle 200 restarts the whole fill.
    repeat (200) @(posedge clk);
    #1;
    check("mid.busy", 32'(init_busy_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    count_busy(n, gs, rs);
    check("mid.busy_cycles", 32'(n), 32'd512);
    check("mid.no_rvalid", 32'(rs), 32'd0);
    access("mid.clr0010", 1'b0, 32'h0010, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    access("mid.clr0804", 1'b0, 32'h0804, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    access("mid.clr1814", 1'b0, baddr[3], 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
